// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// downstream hold; counts inserted load-use bubbles.
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int REGADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    pc_id,
  input  logic [REGADDR_WIDTH-1:0] rs1_addr_id,
  input  logic [REGADDR_WIDTH-1:0] rs2_addr_id,
  input  logic [REGADDR_WIDTH-1:0] rd_addr_id,
  input  logic [DATA_WIDTH-1:0]    rs1_data_id,
  input  logic [DATA_WIDTH-1:0]    rs2_data_id,
  input  logic [DATA_WIDTH-1:0]    imm_id,
  input  logic [8:0]               ctrl_id,
  input  logic                     flush_ex,
  input  logic                     ex_hold,
  output logic                     stall_id,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    pc_ex,
  output logic [DATA_WIDTH-1:0]    rs1_data_ex,
  output logic [DATA_WIDTH-1:0]    rs2_data_ex,
  output logic [DATA_WIDTH-1:0]    imm_ex,
  output logic [REGADDR_WIDTH-1:0] rs1_addr_ex,
  output logic [REGADDR_WIDTH-1:0] rs2_addr_ex,
  output logic [REGADDR_WIDTH-1:0] rd_addr_ex,
  output logic [8:0]               ctrl_ex,
  output logic                     regs_write_ex,
  output logic                     mem_read_ex,
  output logic [15:0]              bubble_cnt
);

  localparam logic [REGADDR_WIDTH-1:0] ZERO_ADDR = {REGADDR_WIDTH{1'b0}};

  logic                     ex_valid_r;
  logic [DATA_WIDTH-1:0]    pc_ex_r;
  logic [DATA_WIDTH-1:0]    rs1_data_ex_r;
  logic [DATA_WIDTH-1:0]    rs2_data_ex_r;
  logic [DATA_WIDTH-1:0]    imm_ex_r;
  logic [REGADDR_WIDTH-1:0] rs1_addr_ex_r;
  logic [REGADDR_WIDTH-1:0] rs2_addr_ex_r;
  logic [REGADDR_WIDTH-1:0] rd_addr_ex_r;
  logic [8:0]               ctrl_ex_r;
  logic                     regs_write_ex_r;
  logic                     mem_read_ex_r;
  logic [15:0]              bubble_cnt_r;
  logic                     hz_s;
  logic                     stall_s;

  // Load-use hazard detection and ID stall request (stall is masked in reset)
  always_comb begin
    hz_s    = 1'b0;
    stall_s = 1'b0;
    if (ex_valid_r && mem_read_ex_r && (rd_addr_ex_r != ZERO_ADDR) && id_valid &&
        ((rd_addr_ex_r == rs1_addr_id) || (rd_addr_ex_r == rs2_addr_id))) begin
      hz_s = 1'b1;
    end else begin
      hz_s = 1'b0;
    end
    if (rst_n) begin
      stall_s = ex_hold | (hz_s & ~flush_ex);
    end else begin
      stall_s = 1'b0;
    end
  end

  // Pipeline register update: flush > hold > load-use bubble > normal load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r      <= 1'b0;
      pc_ex_r         <= {DATA_WIDTH{1'b0}};
      rs1_data_ex_r   <= {DATA_WIDTH{1'b0}};
      rs2_data_ex_r   <= {DATA_WIDTH{1'b0}};
      imm_ex_r        <= {DATA_WIDTH{1'b0}};
      rs1_addr_ex_r   <= ZERO_ADDR;
      rs2_addr_ex_r   <= ZERO_ADDR;
      rd_addr_ex_r    <= ZERO_ADDR;
      ctrl_ex_r       <= 9'd0;
      regs_write_ex_r <= 1'b0;
      mem_read_ex_r   <= 1'b0;
      bubble_cnt_r    <= 16'd0;
    end else if (flush_ex) begin
      ex_valid_r      <= 1'b0;
      ctrl_ex_r       <= 9'd0;
      regs_write_ex_r <= 1'b0;
      mem_read_ex_r   <= 1'b0;
    end else if (ex_hold) begin
      ex_valid_r      <= ex_valid_r;
    end else if (hz_s) begin
      ex_valid_r      <= 1'b0;
      ctrl_ex_r       <= 9'd0;
      regs_write_ex_r <= 1'b0;
      mem_read_ex_r   <= 1'b0;
      if (bubble_cnt_r != 16'hFFFF) begin
        bubble_cnt_r <= bubble_cnt_r + 16'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end else begin
      ex_valid_r      <= id_valid;
      pc_ex_r         <= pc_id;
      rs1_data_ex_r   <= rs1_data_id;
      rs2_data_ex_r   <= rs2_data_id;
      imm_ex_r        <= imm_id;
      rs1_addr_ex_r   <= rs1_addr_id;
      rs2_addr_ex_r   <= rs2_addr_id;
      rd_addr_ex_r    <= rd_addr_id;
      ctrl_ex_r       <= id_valid ? ctrl_id : 9'd0;
      // qualified flags are precomputed so they leave the stage registered
      regs_write_ex_r <= id_valid & ctrl_id[1] & (rd_addr_id != ZERO_ADDR);
      mem_read_ex_r   <= id_valid & ctrl_id[3];
    end
  end

  assign stall_id      = stall_s;
  assign ex_valid      = ex_valid_r;
  assign pc_ex         = pc_ex_r;
  assign rs1_data_ex   = rs1_data_ex_r;
  assign rs2_data_ex   = rs2_data_ex_r;
  assign imm_ex        = imm_ex_r;
  assign rs1_addr_ex   = rs1_addr_ex_r;
  assign rs2_addr_ex   = rs2_addr_ex_r;
  assign rd_addr_ex    = rd_addr_ex_r;
  assign ctrl_ex       = ctrl_ex_r;
  assign regs_write_ex = regs_write_ex_r;
  assign mem_read_ex   = mem_read_ex_r;
  assign bubble_cnt    = bubble_cnt_r;

endmodule
